// File: rtl/instr_issue.sv
// instr_issue: MIPS fetch front end. It fetches over req/ack, decodes at FIFO write, and issues over valid/ready.
// Build macro ISSUE_ILLEGAL_TRAP_EN: an illegal instruction stops fetch and raises halted until a redirect.
module instr_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_flags,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_illegal,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [12:0] flags;
        logic        illegal;
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    function automatic entry_t decode_word(input logic [31:0] word, input logic [31:0] pc);
        entry_t e;
        e.flags = 13'd0;
        e.instr = word;
        e.pc    = pc;
        case (word[31:26])
            6'h00: begin
                case (word[5:0])
                    6'h21:   e.flags[0]  = 1'b1;
                    6'h23:   e.flags[1]  = 1'b1;
                    6'h2a:   e.flags[9]  = 1'b1;
                    6'h08:   e.flags[12] = 1'b1;
                    default: e.flags     = 13'd0;
                endcase
            end
            6'h0d:   e.flags[2]  = 1'b1;
            6'h23:   e.flags[3]  = 1'b1;
            6'h2b:   e.flags[4]  = 1'b1;
            6'h04:   e.flags[5]  = 1'b1;
            6'h0f:   e.flags[6]  = 1'b1;
            6'h08:   e.flags[7]  = 1'b1;
            6'h09:   e.flags[8]  = 1'b1;
            6'h02:   e.flags[10] = 1'b1;
            6'h03:   e.flags[11] = 1'b1;
            default: e.flags     = 13'd0;
        endcase
        // The all-zero word is the canonical nop and is not illegal.
        e.illegal = (e.flags == 13'd0) && (word != 32'd0);
        return e;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_s;
    logic [31:0] fetch_pc_inc_s;
    logic [31:0] addr_r;
    logic [31:0] addr_s;
    logic        req_r;
    logic        valid_r;
    logic [1:0]  count_r;
    logic [1:0]  count_s;
    logic [1:0]  wr_idx_s;
    entry_t      slot0_r;
    entry_t      slot1_r;
    entry_t      slot0_s;
    entry_t      slot1_s;
    entry_t      new_entry_s;
    logic [31:0] redirect_target_s;
    logic        pop_s;
    logic        push_s;
    logic        stop_r;
    logic        stop_hit_s;

    assign redirect_target_s = {redirect_pc[31:2], 2'b00};
    assign fetch_pc_inc_s    = fetch_pc_r + 32'd4;
    assign pop_s             = valid_r && out_ready && !redirect_valid;
    assign new_entry_s       = decode_word(imem_rdata, addr_r);

`ifdef ISSUE_ILLEGAL_TRAP_EN
    logic halted_r;

    assign stop_hit_s = new_entry_s.illegal;

    // Fetch-stop and halt flags; only a redirect releases them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_r   <= 1'b0;
            halted_r <= 1'b0;
        end else if (redirect_valid) begin
            stop_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            if (push_s && new_entry_s.illegal) begin
                stop_r <= 1'b1;
            end
            if (pop_s && stop_r && slot0_r.illegal) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign halted = halted_r;
`else
    assign stop_r     = 1'b0;
    assign stop_hit_s = 1'b0;
    assign halted     = 1'b0;
`endif

    // Fetch FSM next-state, next fetch PC and request address.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        addr_s     = addr_r;
        push_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_s = redirect_target_s;
                    addr_s     = redirect_target_s;
                    state_s    = REQ;
                end else if (!stop_r && ((count_r - {1'b0, pop_s}) < 2'd2)) begin
                    addr_s  = fetch_pc_r;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_s = redirect_target_s;
                    if (imem_ack) begin
                        addr_s  = redirect_target_s;
                        state_s = REQ;
                    end else begin
                        state_s = DISCARD;
                    end
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_s = fetch_pc_inc_s;
                    // Keep requesting only if the slot after this push stays free.
                    if (((count_r - {1'b0, pop_s}) == 2'd0) && !stop_hit_s) begin
                        addr_s  = fetch_pc_inc_s;
                        state_s = REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_s = redirect_target_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
                if (imem_ack) begin
                    addr_s  = fetch_pc_s;
                    state_s = REQ;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Two-entry shifting FIFO: slot0 is always the head, so outputs come straight from flops.
    always_comb begin
        slot0_s  = slot0_r;
        slot1_s  = slot1_r;
        wr_idx_s = count_r - {1'b0, pop_s};
        if (redirect_valid) begin
            count_s = 2'd0;
        end else begin
            count_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
        if (pop_s) begin
            slot0_s = slot1_r;
        end else begin
            slot0_s = slot0_r;
        end
        if (push_s) begin
            if (wr_idx_s == 2'd0) begin
                slot0_s = new_entry_s;
            end else begin
                slot1_s = new_entry_s;
            end
        end else begin
            slot1_s = slot1_r;
        end
    end

    // State, PC, request and FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            count_r    <= 2'd0;
            slot0_r    <= {$bits(entry_t){1'b0}};
            slot1_r    <= {$bits(entry_t){1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
            req_r      <= (state_s != IDLE);
            valid_r    <= (count_s != 2'd0);
            count_r    <= count_s;
            slot0_r    <= slot0_s;
            slot1_r    <= slot1_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign out_valid   = valid_r;
    assign out_flags   = slot0_r.flags;
    assign out_instr   = slot0_r.instr;
    assign out_pc      = slot0_r.pc;
    assign out_illegal = slot0_r.illegal;

endmodule
